// File: rtl/regfile_pkg.sv
// Register-file geometry and writeback source indices shared by the
// write-port arbiter and its clients.
package regfile_pkg;

   localparam int REG_WIDTH  = 8;
   localparam int REG_AWIDTH = 3;

   localparam int SRC_ALU = 0;
   localparam int SRC_MEM = 1;

   // Width of a source index; a single source still needs one bit.
   function automatic int src_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin first-one finder: picks the first set request
// at or after the pointer, wrapping from N-1 back to 0.
module rr_picker #(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [N-1:0]  o_grant,
   output logic [PW-1:0] o_idx,
   output logic          o_any
);

   int w_dist;
   int w_best;

   // Each request's rotated distance from the pointer; the nearest wins.
   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      w_best  = N;
      w_dist  = 0;
      for (int j = 0; j < N; j++) begin
         w_dist = j - int'(i_ptr);
         if (w_dist < 0) w_dist = w_dist + N;
         if (i_req[j] && (w_dist < w_best)) begin
            w_best     = w_dist;
            o_grant    = '0;
            o_grant[j] = 1'b1;
            o_idx      = PW'(j);
            o_any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ
// writeback sources, with a registered one-cycle write pulse.
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int WIDTH  = REG_WIDTH,
   parameter int AWIDTH = REG_AWIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*AWIDTH-1:0]   req_addr,
   input  logic [NREQ*WIDTH-1:0]    req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     wr_en,
   output logic [AWIDTH-1:0]        wr_addr,
   output logic [WIDTH-1:0]         wr_data,
   output logic [src_w(NREQ)-1:0]   wr_src
);

   localparam int SW = src_w(NREQ);

   logic [NREQ-1:0]   w_req;
   logic [NREQ-1:0]   w_grant;
   logic [SW-1:0]     w_idx;
   logic              w_any;
   logic [AWIDTH-1:0] w_addr;
   logic [WIDTH-1:0]  w_data;
   logic [SW-1:0]     w_ptr_nxt;

   logic [SW-1:0]     r_ptr;
   logic              r_vld_p1;
   logic [AWIDTH-1:0] r_addr_p1;
   logic [WIDTH-1:0]  r_data_p1;
   logic [SW-1:0]     r_src_p1;

   // Masking the requests makes a transfer impossible while stalled or in reset.
   assign w_req = (stall || rst) ? '0 : req_valid;

   rr_picker #(
      .N  (NREQ),
      .PW (SW)
   ) u_picker (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign req_ready = w_grant;

   always_comb begin
      w_addr = '0;
      w_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_addr = req_addr[i*AWIDTH +: AWIDTH];
            w_data = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign w_ptr_nxt = (w_idx == SW'(NREQ - 1)) ? '0 : w_idx + SW'(1);

   // ---- stage p0 -> p1: granted write registered onto the port ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= '0;
         r_vld_p1  <= 1'b0;
         r_addr_p1 <= '0;
         r_data_p1 <= '0;
         r_src_p1  <= '0;
      end else begin
         r_vld_p1 <= w_any;
         if (w_any) begin
            r_ptr     <= w_ptr_nxt;
            r_addr_p1 <= w_addr;
            r_data_p1 <= w_data;
            r_src_p1  <= w_idx;
         end
      end
   end

   assign wr_en   = r_vld_p1;
   assign wr_addr = r_addr_p1;
   assign wr_data = r_data_p1;
   assign wr_src  = r_src_p1;

endmodule
